// File: rtl/uart_pkg.sv
// Shared types and framing constants for the 16-bit command UART transmitter.
// Optional even parity is enabled by defining UART_CMD_TX_PARITY_EN.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HIGH_BYTE,
    LOW_BYTE
  } tx_state_t;

  // Bits per byte on the wire: start + 8 data (+ parity) + stop.
`ifdef UART_CMD_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  localparam logic UART_IDLE_LVL = 1'b1;

  // Everything after the start bit is preloaded into the shift register.
  localparam int SHIFT_W = FRAME_BITS - 1;

endpackage

// File: rtl/uart_tx_byte.sv
// Byte serializer: one start bit, LSB-first data, optional even parity
// (UART_CMD_TX_PARITY_EN), one stop bit, each held BAUD_DIV clocks.
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       TX,
  output logic       tx_done
);

  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [3:0] BIT_LAST = 4'(FRAME_BITS - 1);

  logic [CNT_W-1:0]   r_baudCnt;
  logic [3:0]         r_bitCnt;
  logic [SHIFT_W-1:0] r_shift;
  logic               r_busy;
  logic               r_tx;
  logic               w_baudEnd;
  logic [SHIFT_W-1:0] w_load;

`ifdef UART_CMD_TX_PARITY_EN
  assign w_load = {UART_IDLE_LVL, ^tx_data, tx_data};
`else
  assign w_load = {UART_IDLE_LVL, tx_data};
`endif

  assign w_baudEnd = r_busy && (r_baudCnt == BAUD_LAST);
  assign tx_done   = w_baudEnd && (r_bitCnt == BIT_LAST);
  assign TX        = r_tx;

  // A new trmt wins over the finishing stop bit so back-to-back bytes
  // leave no idle gap on the line.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_baudCnt <= '0;
      r_bitCnt  <= '0;
      r_shift   <= '0;
      r_busy    <= 1'b0;
      r_tx      <= UART_IDLE_LVL;
    end else if (trmt) begin
      r_baudCnt <= '0;
      r_bitCnt  <= '0;
      r_shift   <= w_load;
      r_busy    <= 1'b1;
      r_tx      <= 1'b0;
    end else if (r_busy) begin
      if (w_baudEnd) begin
        r_baudCnt <= '0;
        if (r_bitCnt == BIT_LAST) begin
          r_busy   <= 1'b0;
          r_bitCnt <= '0;
        end else begin
          r_bitCnt <= r_bitCnt + 4'd1;
          r_tx     <= r_shift[0];
          r_shift  <= {UART_IDLE_LVL, r_shift[SHIFT_W-1:1]};
        end
      end else begin
        r_baudCnt <= r_baudCnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/uart_cmd_tx.sv
// Command-link transmitter: sends a 16-bit word as two UART bytes, high first.
// Define UART_CMD_TX_PARITY_EN for even parity on each byte.
module uart_cmd_tx
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        snd_cmd,
  input  logic [15:0] cmd,
  output logic        TX,
  output logic        tx_busy,
  output logic        cmd_cmplt
);

  tx_state_t   r_state;
  tx_state_t   w_nextState;
  logic [7:0]  r_shadowLo;
  logic        r_txBusy;
  logic        r_cmdCmplt;
  logic        w_trmt;
  logic [7:0]  w_txData;
  logic        w_txDone;
  logic        w_accept;
  logic        w_finish;

  // The high byte goes straight from cmd into the serializer's shift register
  // on the accepting cycle, so only the low half needs a shadow copy.
  always_comb begin
    w_nextState = r_state;
    w_trmt      = 1'b0;
    w_txData    = cmd[15:8];
    w_accept    = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      IDLE: begin
        if (snd_cmd) begin
          w_accept    = 1'b1;
          w_trmt      = 1'b1;
          w_nextState = HIGH_BYTE;
        end
      end
      HIGH_BYTE: begin
        if (w_txDone) begin
          w_trmt      = 1'b1;
          w_txData    = r_shadowLo;
          w_nextState = LOW_BYTE;
        end
      end
      LOW_BYTE: begin
        if (w_txDone) begin
          w_finish    = 1'b1;
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_shadowLo <= '0;
      r_txBusy   <= 1'b0;
      r_cmdCmplt <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if (w_accept) begin
        r_shadowLo <= cmd[7:0];
        r_txBusy   <= 1'b1;
        r_cmdCmplt <= 1'b0;
      end
      if (w_finish) begin
        r_txBusy   <= 1'b0;
        r_cmdCmplt <= 1'b1;
      end
    end
  end

  assign tx_busy   = r_txBusy;
  assign cmd_cmplt = r_cmdCmplt;

  uart_tx_byte #(
    .BAUD_DIV(BAUD_DIV)
  ) u_txByte (
    .clk    (clk),
    .rst    (rst),
    .trmt   (w_trmt),
    .tx_data(w_txData),
    .TX     (TX),
    .tx_done(w_txDone)
  );

endmodule

// File: tb/tb_uart_cmd_tx.sv
// Self-checking bench for uart_cmd_tx at BAUD_DIV=4; honours UART_CMD_TX_PARITY_EN.
module tb_uart_cmd_tx;
  import uart_pkg::*;

  localparam int B   = 4;
  localparam int NB  = 2 * FRAME_BITS;
  localparam int LAT = NB * B;
`ifdef UART_CMD_TX_PARITY_EN
  localparam int LAT_LIT = 88;
`else
  localparam int LAT_LIT = 80;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        snd_cmd;
  logic [15:0] cmd;
  logic        TX;
  logic        tx_busy;
  logic        cmd_cmplt;

  always #5 clk = ~clk;

  uart_cmd_tx #(.BAUD_DIV(B)) dut (
    .clk      (clk),
    .rst      (rst),
    .snd_cmd  (snd_cmd),
    .cmd      (cmd),
    .TX       (TX),
    .tx_busy  (tx_busy),
    .cmd_cmplt(cmd_cmplt)
  );

  int   nChecks = 0;
  int   nFails  = 0;
  bit   checkEn = 1'b0;

  // Reference model: a queue of the line levels still owed, one per clock.
  logic mTxQ[$];
  bit   mBusy  = 1'b0;
  bit   mCmplt = 1'b0;

  function automatic void pushLevel(input logic lvl);
    for (int i = 0; i < B; i++) mTxQ.push_back(lvl);
  endfunction

  function automatic void pushByte(input logic [7:0] b);
    pushLevel(1'b0);
    for (int i = 0; i < 8; i++) pushLevel(b[i]);
`ifdef UART_CMD_TX_PARITY_EN
    pushLevel(^b);
`endif
    pushLevel(1'b1);
  endfunction

  always @(posedge clk) begin
    bit wasBusy;
    wasBusy = mBusy;
    if (rst) begin
      mTxQ.delete();
      mBusy  = 1'b0;
      mCmplt = 1'b0;
    end else begin
      if (mTxQ.size() > 0) begin
        void'(mTxQ.pop_front());
        if (mTxQ.size() == 0) begin
          mBusy  = 1'b0;
          mCmplt = 1'b1;
        end
      end
      if (snd_cmd && !wasBusy) begin
        mBusy  = 1'b1;
        mCmplt = 1'b0;
        pushByte(cmd[15:8]);
        pushByte(cmd[7:0]);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkStr(input string name, input string act, input string exp);
    nChecks++;
    if (act != exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %s, expected %s", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      check("TX vs model", TX, (mTxQ.size() > 0) ? mTxQ[0] : UART_IDLE_LVL);
      check("tx_busy vs model", tx_busy, mBusy);
      check("cmd_cmplt vs model", cmd_cmplt, mCmplt);
    end
  end

  // Called at a negedge with the DUT idle. Sends w, optionally changes cmd /
  // pulses snd_cmd at frame cycle pulseAt, samples each bit mid-period and
  // returns the cycles from first start-bit cycle to cmd_cmplt.
  task automatic applyStimulus(input logic [15:0] w, input int pulseAt,
                               input logic [15:0] altCmd, input bit altSnd,
                               output string bits, output int lat);
    bits    = "";
    lat     = -1;
    snd_cmd = 1'b1;
    cmd     = w;
    @(posedge clk);
    for (int c = 0; c < LAT + 40; c++) begin
      @(negedge clk);
      if (c == 0) begin
        snd_cmd = 1'b0;
        check("cmplt cleared on accept", cmd_cmplt, 1'b0);
        check("busy set on accept", tx_busy, 1'b1);
      end
      if (c == pulseAt) begin
        cmd     = altCmd;
        snd_cmd = altSnd;
      end else if (c == pulseAt + 1) begin
        snd_cmd = 1'b0;
      end
      if (c < LAT && (c % B) == B / 2) begin
        if (TX) bits = {bits, "1"};
        else    bits = {bits, "0"};
      end
      if (cmd_cmplt) begin
        lat = c;
        break;
      end
    end
    snd_cmd = 1'b0;
  endtask

  task automatic checkOutput(input string name, input string bits, input string expBits,
                             input int lat);
`ifndef UART_CMD_TX_PARITY_EN
    checkStr({name, " bits"}, bits, expBits);
`endif
    check({name, " latency"}, lat, LAT_LIT);
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL global timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    string bits;
    int    lat;
    rst     = 1'b1;
    snd_cmd = 1'b0;
    cmd     = '0;
    repeat (3) @(posedge clk);
    checkEn = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // Idle after reset
    check("reset TX", TX, 1'b1);
    check("reset tx_busy", tx_busy, 1'b0);
    check("reset cmd_cmplt", cmd_cmplt, 1'b0);
    repeat (50) @(negedge clk);
    check("idle TX", TX, 1'b1);

    // Basic word
    applyStimulus(16'hA55A, -10, 16'h0, 1'b0, bits, lat);
    checkOutput("A55A", bits, "01010010110010110101", lat);

    // Request mid-transfer is dropped
    applyStimulus(16'hA55A, 30, 16'h1234, 1'b1, bits, lat);
    checkOutput("A55A ignore", bits, "01010010110010110101", lat);

    // Request on the completing cycle is dropped; the next cycle is accepted
    applyStimulus(16'h1234, LAT - 1, 16'hBEEF, 1'b1, bits, lat);
    checkOutput("1234", bits, "00100100010001011001", lat);
    applyStimulus(16'h00FF, 0, 16'hFFFF, 1'b0, bits, lat);
    checkOutput("00FF shadow", bits, "00000000010111111111", lat);

    // Reset during frame bit 3 of the high byte
    snd_cmd = 1'b1;
    cmd     = 16'hC3C3;
    @(posedge clk);
    @(negedge clk);
    snd_cmd = 1'b0;
    repeat (3 * B) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort TX", TX, 1'b1);
    check("abort tx_busy", tx_busy, 1'b0);
    check("abort cmd_cmplt", cmd_cmplt, 1'b0);
    repeat (5) @(negedge clk);
    applyStimulus(16'h0F0F, -10, 16'h0, 1'b0, bits, lat);
    checkOutput("0F0F", bits, "01111000010111100001", lat);

`ifdef UART_CMD_TX_PARITY_EN
    applyStimulus(16'h0301, -10, 16'h0, 1'b0, bits, lat);
    checkStr("0301 parity bits", bits, "0110000000101000000011");
    check("0301 latency", lat, LAT_LIT);
`endif

    // Randomized words with stray requests and idle gaps
    for (int n = 0; n < 10; n++) begin
      applyStimulus(16'($urandom), int'($urandom_range(0, LAT - 1)), 16'($urandom),
                    1'($urandom_range(0, 1)), bits, lat);
      check("random latency", lat, LAT_LIT);
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    checkEn = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
